right_shift_pipeline_param: RTL
===============================

RIGHT_SHIFT_PIPELINE_PARAM -- requirements
Module: right_shift_pipeline_param

Interface
REQ-001 Parameter N, default 8: data width in bits; SHALL be a power of two and at least 2.
REQ-002 Parameter SW, default $clog2(N): shift-amount width; SHALL not be overridden.
REQ-003 Port clk, input, 1: the single clock; all state SHALL be on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous reset, active-low.
REQ-005 Port in_valid, input, 1: an input beat is offered.
REQ-006 Port in_ready, output, 1: the block can accept an input beat.
REQ-007 Port in_data, input, N: operand, unsigned except in SRA mode.
REQ-008 Port in_amt, input, SW: shift amount, 0 to N-1.
REQ-009 Port in_mode, input, 2: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-010 Port out_valid, output, 1: a result beat is offered.
REQ-011 Port out_ready, input, 1: the downstream consumer accepts the result beat.
REQ-012 Port out_data, output, N: the result.

Function
REQ-013 A beat SHALL transfer on an input when valid and ready are both 1 at the rising clk edge; out_valid/out_ready SHALL follow the same rule.
REQ-014 The datapath SHALL be SW registered stages; stage k SHALL shift by 2**k when in_amt[k] is 1, otherwise pass the data through.
REQ-015 Latency SHALL be exactly SW cycles from input transfer to out_valid=1 when there is no backpressure; throughput SHALL be one beat per cycle.
REQ-016 SLL SHALL zero-fill from the LSB.
REQ-017 SRL SHALL zero-fill from the MSB.
REQ-018 SRA SHALL fill from the MSB with in_data[N-1].
REQ-019 ROR SHALL feed the bits shifted out of the LSB back in at the MSB.
REQ-020 in_amt=0 SHALL return in_data unchanged in every mode.
REQ-021 Each stage SHALL hold a valid bit, data, the remaining amount bits and the mode.
REQ-022 A stage SHALL load when the stage after it is empty or advancing in the same cycle (bubble-collapsing).
REQ-023 in_ready SHALL be the load condition of stage 0.
REQ-024 While out_valid=1 and out_ready=0, out_data SHALL hold stable and no held beat SHALL be lost or duplicated.
REQ-025 An input transfer and an output transfer in the same cycle with a full pipeline SHALL both complete.
REQ-026 Order of beats SHALL be preserved.

Reset
REQ-027 rst_n=0 SHALL clear every stage valid bit immediately, without waiting for clk; out_valid SHALL be 0.
REQ-028 out_data SHALL be 0 during reset; data registers SHALL reset to 0.
REQ-029 Beats in flight at a mid-operation reset SHALL be discarded.
REQ-030 in_ready SHALL be 1 on the first edge after rst_n deasserts.

Configuration
REQ-031 Macro RIGHT_SHIFT_PIPELINE_ROTATE_EN, when defined, SHALL compile in ROR as specified in REQ-019.
REQ-032 When that macro is not defined, mode 11 SHALL behave exactly as SRL and no rotate wrap logic SHALL be synthesised.

Structure
REQ-033 Package shift_pkg SHALL hold the 2-bit mode enum (SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROR) and shared mode constants.
REQ-034 SLL SHALL be implemented as bit-reverse, right shift, bit-reverse, so that only one right-shift datapath exists.
REQ-035 Sub-module right_shift_stage, parameters N and K, SHALL implement one combinational stage (shift by 2**K, select the fill or wrap bits); the top SHALL generate SW instances plus their registers.

Verification
REQ-036 Mode coverage, N=8, in_data=8'b1011_0001, in_amt=3, out_ready=1:
- SLL -> 8'b1000_1000
- SRL -> 8'b0001_0110
- SRA -> 8'b1111_0110
- ROR -> 8'b0011_0110 (macro defined); 8'b0001_0110 (macro undefined)
- each result SHALL appear 3 cycles after acceptance.
REQ-037 Zero shift: in_amt=0, any mode, in_data=8'hA5 -> out_data=8'hA5.
REQ-038 Streaming: 20 back-to-back random beats with out_ready=1 -> one result per cycle; each result SHALL match a >>, <<, >>> or rotate model.
REQ-039 Backpressure:
- hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 within 3 cycles; out_data stable.
- then release out_ready -> all accepted beats SHALL emerge in order, none lost.
REQ-040 Reset mid-stream: pull rst_n low with 2 beats in flight -> out_valid=0 immediately; after release, no stale beat SHALL appear.
REQ-041 Parameter sweep: N=2, 16 and 32 with random stimulus -> results match the model; latency equals $clog2(N).

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: shift-mode encoding shared by the right-shift pipeline and its stages.
// The rotate mode is only honoured when RIGHT_SHIFT_PIPELINE_ROTATE_EN is defined.
package shift_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_mode_e;

    localparam logic [MODE_W-1:0] MODE_RESET = SHIFT_SLL;

endpackage

// File: rtl/right_shift_stage.sv
// right_shift_stage: one combinational step, shifts right by 2**K when enabled.
// Wrap-around for ROR exists only under RIGHT_SHIFT_PIPELINE_ROTATE_EN.
module right_shift_stage
    import shift_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 0
) (
    input  logic [N-1:0]      data_i,
    input  logic              en_i,
    input  logic [MODE_W-1:0] mode_i,
    output logic [N-1:0]      data_o
);

    localparam int S = 2 ** K;

    logic [N-1:0] shifted;
    logic [N-1:0] fill_mask;
    logic [N-1:0] fill;

    assign shifted   = data_i >> S;
    assign fill_mask = ~({N{1'b1}} >> S);

`ifdef RIGHT_SHIFT_PIPELINE_ROTATE_EN
    always_comb begin
        fill = '0;
        if (mode_i == SHIFT_ROR) begin
            fill = data_i << (N - S);
        end else if (mode_i == SHIFT_SRA) begin
            fill = fill_mask & {N{data_i[N-1]}};
        end
    end
`else
    // Mode 11 degrades to a plain logical shift with zero fill.
    always_comb begin
        fill = '0;
        if (mode_i == SHIFT_SRA) begin
            fill = fill_mask & {N{data_i[N-1]}};
        end
    end
`endif

    assign data_o = en_i ? (shifted | fill) : data_i;

endmodule

// File: rtl/right_shift_pipeline_param.sv
// right_shift_pipeline_param: SW-stage valid/ready barrel shifter (SLL/SRL/SRA/ROR).
// ROR wrap is compiled in only with RIGHT_SHIFT_PIPELINE_ROTATE_EN defined.
module right_shift_pipeline_param
    import shift_pkg::*;
#(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [SW-1:0] in_amt,
    input  logic [1:0]    in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data
);

    logic [SW-1:0] vld;
    logic [SW-1:0] load;
    logic [N-1:0]  in_rev;
    logic [N-1:0]  in_sel;
    logic [N-1:0]  out_raw;
    logic [N-1:0]  out_rev;
    logic [1:0]    out_mode;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_rev[i]  = in_data[N-1-i];
            out_rev[i] = out_raw[N-1-i];
        end
    end

    // SLL travels bit-reversed so a single right-shift datapath serves all modes.
    assign in_sel = (in_mode == SHIFT_SLL) ? in_rev : in_data;

    // A stage loads if any stage at or after it is empty, or the output drains.
    always_comb begin
        logic hole;
        hole = out_ready;
        for (int k = SW - 1; k >= 0; k--) begin
            hole    = hole || !vld[k];
            load[k] = hole;
        end
    end

    assign in_ready = load[0];

    for (genvar k = 0; k < SW; k++) begin : g_st
        localparam int RW = SW - k;

        logic          vld_i;
        logic [N-1:0]  dat_i;
        logic [1:0]    mode_i;
        logic [RW-1:0] rem_i;
        logic [N-1:0]  dat_d;
        logic          vld_q;
        logic [N-1:0]  dat_q;
        logic [1:0]    mode_q;

        if (k == 0) begin : g_head
            assign vld_i  = in_valid;
            assign dat_i  = in_sel;
            assign mode_i = in_mode;
            assign rem_i  = in_amt;
        end else begin : g_body
            assign vld_i  = g_st[k-1].vld_q;
            assign dat_i  = g_st[k-1].dat_q;
            assign mode_i = g_st[k-1].mode_q;
            assign rem_i  = g_st[k-1].g_rem.rem_q;
        end

        right_shift_stage #(
            .N (N),
            .K (k)
        ) u_stage (
            .data_i (dat_i),
            .en_i   (rem_i[0]),
            .mode_i (mode_i),
            .data_o (dat_d)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q  <= 1'b0;
                dat_q  <= '0;
                mode_q <= MODE_RESET;
            end else if (load[k]) begin
                vld_q  <= vld_i;
                dat_q  <= dat_d;
                mode_q <= mode_i;
            end
        end

        // Only the amount bits still to be applied travel forward.
        if (RW > 1) begin : g_rem
            logic [RW-2:0] rem_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rem_q <= '0;
                end else if (load[k]) begin
                    rem_q <= rem_i[RW-1:1];
                end
            end
        end

        assign vld[k] = vld_q;
    end

    assign out_raw   = g_st[SW-1].dat_q;
    assign out_mode  = g_st[SW-1].mode_q;
    assign out_valid = vld[SW-1];
    assign out_data  = (out_mode == SHIFT_SLL) ? out_rev : out_raw;

endmodule
